// File: rtl/ysyx_23060124_icache_sa.sv
// N-way set-associative read-only instruction cache with combinational lookup and
// round-robin victim selection; optional ICACHE_PERF_EN adds hit/miss counters.
module ysyx_23060124_icache_sa #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SETS       = 8,
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst_sync,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  fence_i,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  refill_err,
`ifdef ICACHE_PERF_EN
    output logic [31:0]           perf_hit,
    output logic [31:0]           perf_miss,
`endif
    output logic [31:0]           M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    output logic [3:0]            M_AXI_ARID,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    input  logic [31:0]           M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic [3:0]            M_AXI_RID,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int OFFSET_BITS = $clog2(4 * WORDS_PER_LINE);
    localparam int WORD_BITS   = OFFSET_BITS - 2;
    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int IDX_W       = (INDEX_BITS > 0) ? INDEX_BITS : 1;
    localparam int WAY_BITS    = $clog2(NUM_WAYS);
    localparam int WAY_W       = (WAY_BITS > 0) ? WAY_BITS : 1;
    localparam int TAG_W       = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
    localparam int LINE_W      = ADDR_WIDTH - OFFSET_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_RD
    } state_t;

    state_t state_q, state_d;

    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];
    logic [WAY_W-1:0]      rr_q    [NUM_SETS];

    logic [LINE_W-1:0]    line_q, line_d;
    logic [IDX_W-1:0]     set_q, set_d;
    logic [WAY_W-1:0]     victim_q, victim_d;
    logic [WORD_BITS-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 fence_pend_q, fence_pend_d;
    logic                 refill_err_q, refill_err_d;

    logic [TAG_W-1:0]     lookup_tag;
    logic [IDX_W-1:0]     lookup_set;
    logic [WORD_BITS-1:0] lookup_word;

    logic [NUM_WAYS-1:0]   way_hit;
    logic [DATA_WIDTH-1:0] way_data [NUM_WAYS];

    logic             start_miss;
    logic             ar_fire;
    logic             beat;
    logic             burst_end;
    logic             burst_err;
    logic             fill_ok;
    logic [WAY_W-1:0] rr_next;
    logic             unused_bits;

    assign lookup_tag  = addr[ADDR_WIDTH-1 -: TAG_W];
    assign lookup_word = addr[OFFSET_BITS-1:2];

    generate
        if (INDEX_BITS > 0) begin : g_idx
            assign lookup_set = addr[OFFSET_BITS +: INDEX_BITS];
        end else begin : g_noidx
            assign lookup_set = '0;
        end
    endgenerate

    // Lookup: the in-flight victim has its valid bit cleared, so it can never hit.
    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign way_hit[gi]  = valid_q[lookup_set][gi] && (tag_q[lookup_set][gi] == lookup_tag);
            assign way_data[gi] = way_hit[gi] ? data_q[lookup_set][gi][lookup_word] : '0;
        end
    endgenerate

    assign hit = |way_hit;

    always_comb begin
        data = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            data = data | way_data[w];
        end
    end

    always_comb begin
        state_d    = state_q;
        start_miss = 1'b0;
        ar_fire    = 1'b0;
        beat       = 1'b0;
        burst_end  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !hit && !fence_i) begin
                    state_d    = S_AR;
                    start_miss = 1'b1;
                end
            end
            S_AR: begin
                if (M_AXI_ARREADY) begin
                    state_d = S_RD;
                    ar_fire = 1'b1;
                end
            end
            S_RD: begin
                if (M_AXI_RVALID) begin
                    beat = 1'b1;
                    if (M_AXI_RLAST) begin
                        state_d   = S_IDLE;
                        burst_end = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign burst_err = err_q | M_AXI_RRESP[1];
    // A fence arriving on the RLAST cycle must still leave the line invalid.
    assign fill_ok   = burst_end && !burst_err && !fence_pend_q && !fence_i;
    assign rr_next   = (victim_q == WAY_W'(NUM_WAYS - 1)) ? '0 : victim_q + 1'b1;

    always_comb begin
        line_d       = line_q;
        set_d        = set_q;
        victim_d     = victim_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fence_pend_d = 1'b0;
        refill_err_d = burst_end && burst_err;
        if (start_miss) begin
            line_d   = addr[ADDR_WIDTH-1:OFFSET_BITS];
            set_d    = lookup_set;
            victim_d = rr_q[lookup_set];
        end
        if (ar_fire) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (beat) begin
            cnt_d = cnt_q + 1'b1;
            err_d = burst_err;
        end
        if (state_d != S_IDLE) begin
            fence_pend_d = fence_pend_q | fence_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            set_q        <= '0;
            victim_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            fence_pend_q <= 1'b0;
            refill_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            set_q        <= set_d;
            victim_q     <= victim_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fence_pend_q <= fence_pend_d;
            refill_err_q <= refill_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            if (fence_i) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_q[s] <= '0;
                end
            end else if (start_miss) begin
                valid_q[lookup_set][rr_q[lookup_set]] <= 1'b0;
            end else if (fill_ok) begin
                valid_q[set_q][victim_q] <= 1'b1;
            end
            if (fill_ok) begin
                rr_q[set_q] <= rr_next;
            end
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (start_miss) begin
            tag_q[lookup_set][rr_q[lookup_set]] <= lookup_tag;
        end
        if (beat) begin
            data_q[set_q][victim_q][cnt_q] <= M_AXI_RDATA;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_q;
    logic [31:0] perf_miss_q;

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else if (state_q == S_IDLE && req_valid) begin
            if (hit) begin
                if (perf_hit_q != 32'hFFFF_FFFF) perf_hit_q <= perf_hit_q + 32'd1;
            end else begin
                if (perf_miss_q != 32'hFFFF_FFFF) perf_miss_q <= perf_miss_q + 32'd1;
            end
        end
    end

    assign perf_hit  = perf_hit_q;
    assign perf_miss = perf_miss_q;
`endif

    assign busy          = (state_q != S_IDLE);
    assign refill_err    = refill_err_q;
    assign M_AXI_ARVALID = (state_q == S_AR);
    assign M_AXI_RREADY  = (state_q == S_RD);
    assign M_AXI_ARADDR  = 32'({line_q, {OFFSET_BITS{1'b0}}});
    assign M_AXI_ARID    = 4'd0;
    assign M_AXI_ARLEN   = 8'(WORDS_PER_LINE - 1);
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;

    assign unused_bits = ^{M_AXI_RID, M_AXI_RRESP[0], addr[1:0]};

endmodule

// File: tb/tb_ysyx_23060124_icache_sa.sv
// Randomized bench for the set-associative icache: a line-address level cache model
// predicts hit/data/busy/AXI handshakes every cycle; directed cases pin the model.
module tb_ysyx_23060124_icache_sa;

    localparam int SETS = 8;
    localparam int WAYS = 2;
    localparam int WPL  = 4;

    logic        clk = 1'b0;
    logic        rst_sync = 1'b1;
    logic        req_valid = 1'b0;
    logic        fence_i = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        hit;
    logic [31:0] data;
    logic        busy;
    logic        refill_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rlast = 1'b0;
    logic [3:0]  rid = 4'h0;
    logic        rvalid = 1'b0;
    logic        rready;

    ysyx_23060124_icache_sa dut (
        .clk(clk), .rst_sync(rst_sync), .req_valid(req_valid), .addr(addr), .fence_i(fence_i),
        .hit(hit), .data(data), .busy(busy), .refill_err(refill_err),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_ARID(arid), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RID(rid),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int err_pulses = 0;
    bit checking = 1'b0;
    logic [31:0] last_araddr;

    // Model: which line address each way holds, per-set round-robin pointer, FSM phase.
    bit          m_val [SETS][WAYS];
    logic [31:0] m_line[SETS][WAYS];
    int          m_rr  [SETS];
    bit m_ar, m_rd, m_pend, m_err_now, m_err_next;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        return {w[15:0] ^ 16'hA5A5, w[31:16]};
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 4) & 32'h7);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int s;
        s = set_of(a);
        for (int w = 0; w < WAYS; w++)
            if (m_val[s][w] && m_line[s][w] == (a & ~32'hF)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] bases [4];
        bases[0] = 32'h0000_0000; bases[1] = 32'h0000_0100;
        bases[2] = 32'h8000_0200; bases[3] = 32'h3000_0000;
        return bases[$urandom_range(0, 3)] | (32'($urandom_range(0, 7)) << 4)
             | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h addr=%h t=%0t", name, act, exp, addr, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_err_now  = m_err_next;
        m_err_next = 1'b0;
    endtask

    task automatic model_invalidate();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_val[s][w] = 1'b0;
    endtask

    task automatic model_reset();
        model_invalidate();
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
        m_ar = 0; m_rd = 0; m_pend = 0; m_err_now = 0; m_err_next = 0;
    endtask

    always @(negedge clk) begin
        bit eh;
        if (refill_err) err_pulses++;
        if (checking && !rst_sync) begin
            eh = m_hit(addr);
            chk("hit", 32'(hit), 32'(eh));
            chk("data", data, eh ? mem_word(addr) : 32'h0);
            chk("busy", 32'(busy), 32'(m_ar | m_rd));
            chk("arvalid", 32'(arvalid), 32'(m_ar));
            chk("rready", 32'(rready), 32'(m_rd));
            chk("refill_err", 32'(refill_err), 32'(m_err_now));
        end
    end

    // One IFU request; on a predicted miss the bench plays the AXI slave for the refill.
    task automatic fetch(input logic [31:0] a, input int ar_delay, input int err_beat,
                         input int fence_beat, input int rst_beat, input bit scramble);
        logic [31:0] line;
        int s, v, gaps;
        bit err, last;
        line = a & ~32'hF;
        s = set_of(a);
        addr = a;
        req_valid = 1'b1;
        if (m_hit(a)) begin
            tick();
            req_valid = 1'b0;
            return;
        end
        tick();
        v = m_rr[s];
        m_val[s][v] = 1'b0;
        m_ar = 1'b1;
        for (int i = 0; i < ar_delay; i++) begin
            chk("ar_hold_addr", araddr, line);
            if (scramble) begin addr = rand_addr(); req_valid = 1'($urandom_range(0, 1)); end
            tick();
        end
        chk("araddr", araddr, line);
        chk("arlen", 32'(arlen), 32'(WPL - 1));
        chk("arsize", 32'(arsize), 32'd2);
        chk("arburst", 32'(arburst), 32'd1);
        chk("arid", 32'(arid), 32'd0);
        last_araddr = araddr;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        m_ar = 1'b0;
        m_rd = 1'b1;
        err = 1'b0;
        for (int i = 0; i < WPL; i++) begin
            gaps = scramble ? $urandom_range(0, 2) : 0;
            for (int g = 0; g < gaps; g++) begin
                if (scramble) begin addr = rand_addr(); req_valid = 1'($urandom_range(0, 1)); end
                tick();
            end
            if (i == rst_beat) begin
                rst_sync = 1'b1;
                req_valid = 1'b0;
                tick();
                rst_sync = 1'b0;
                model_reset();
                addr = a;
                return;
            end
            last = (i == WPL - 1);
            rvalid = 1'b1;
            rdata = mem_word(line + 32'(4 * i));
            rresp = (i == err_beat) ? {1'b1, 1'($urandom_range(0, 1))} : {1'b0, 1'($urandom_range(0, 1))};
            rlast = last;
            fence_i = (i == fence_beat);
            if (rresp[1]) err = 1'b1;
            if (last) begin
                addr = a;
                m_err_next = err;
            end
            tick();
            if (fence_i) begin
                model_invalidate();
                m_pend = 1'b1;
                fence_i = 1'b0;
            end
            if (last) begin
                m_rd = 1'b0;
                if (!err && !m_pend) begin
                    m_val[s][v] = 1'b1;
                    m_line[s][v] = line;
                    m_rr[s] = (v + 1) % WAYS;
                end
                m_pend = 1'b0;
                req_valid = 1'b0;
            end
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
    endtask

    task automatic probe(input string name, input logic [31:0] a, input bit exp);
        addr = a;
        req_valid = 1'b0;
        #1;
        chk(name, 32'(hit), 32'(exp));
        tick();
    endtask

    task automatic do_reset();
        rst_sync = 1'b1;
        req_valid = 1'b0;
        tick();
        tick();
        rst_sync = 1'b0;
        model_reset();
    endtask

    initial begin
        int p0, r;
        model_reset();
        repeat (3) tick();
        rst_sync = 1'b0;
        checking = 1'b1;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_arvalid", 32'(arvalid), 32'd0);
        chk("reset_rready", 32'(rready), 32'd0);
        chk("reset_refill_err", 32'(refill_err), 32'd0);
        chk("reset_hit", 32'(hit), 32'd0);
        tick();

        // Conflict in set 0: third fill evicts the way holding 0x0.
        fetch(32'h0000_0000, 0, -1, -1, -1, 0);
        fetch(32'h0000_0100, 1, -1, -1, -1, 0);
        fetch(32'h0000_0200, 0, -1, -1, -1, 0);
        probe("t2_hit_100", 32'h0000_0104, 1'b1);
        probe("t2_hit_200", 32'h0000_020C, 1'b1);
        probe("t2_miss_0", 32'h0000_0000, 1'b0);

        // Cold miss; the line hits with word 2 on the cycle after RLAST.
        fetch(32'h3000_0008, 0, -1, -1, -1, 0);
        #1;
        chk("t1_hit", 32'(hit), 32'd1);
        chk("t1_data", data, 32'hA5AD_3000);
        chk("t1_araddr", last_araddr, 32'h3000_0000);
        tick();

        // Fence mid-burst, then a fence on the RLAST beat itself.
        fetch(32'h0000_0040, 0, -1, 1, -1, 0);
        probe("t3_miss_after_fence", 32'h0000_0040, 1'b0);
        last_araddr = 32'hFFFF_FFFF;
        fetch(32'h0000_0040, 0, -1, -1, -1, 0);
        chk("t3_reissue_araddr", last_araddr, 32'h0000_0040);
        fetch(32'h0000_00C4, 0, -1, WPL - 1, -1, 0);
        probe("t3_fence_on_rlast", 32'h0000_00C4, 1'b0);
        fetch(32'h3000_0000, 0, -1, -1, -1, 0);

        // Error response on beat 1.
        p0 = err_pulses;
        fetch(32'h0000_0084, 0, 1, -1, -1, 0);
        tick();
        tick();
        chk("t4_err_pulses", 32'(err_pulses - p0), 32'd1);
        probe("t4_line_invalid", 32'h0000_0084, 1'b0);
        last_araddr = 32'hFFFF_FFFF;
        fetch(32'h0000_0084, 0, -1, -1, -1, 0);
        chk("t4_reissue_araddr", last_araddr, 32'h0000_0080);
        probe("t4_refilled", 32'h0000_0088, 1'b1);
        probe("t4_neighbour", 32'h3000_0004, 1'b1);

        // ARREADY held low for 10 cycles.
        fetch(32'h5000_0010, 10, -1, -1, -1, 0);

        // Reset in the middle of a burst.
        fetch(32'h0000_0060, 0, -1, -1, 2, 0);
        #1;
        chk("t6_arvalid", 32'(arvalid), 32'd0);
        chk("t6_rready", 32'(rready), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        tick();
        probe("t6_miss_a", 32'h3000_0008, 1'b0);
        probe("t6_miss_b", 32'h0000_0088, 1'b0);

        do_reset();
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                fence_i = 1'b1;
                req_valid = 1'($urandom_range(0, 1));
                addr = rand_addr();
                tick();
                model_invalidate();
                fence_i = 1'b0;
                req_valid = 1'b0;
            end else if (r < 7) begin
                do_reset();
            end else if (r < 20) begin
                req_valid = 1'b0;
                addr = rand_addr();
                tick();
            end else begin
                fetch(rand_addr(), $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, WPL - 1) : -1,
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, WPL - 1) : -1,
                      ($urandom_range(0, 49) == 0) ? $urandom_range(0, WPL - 1) : -1,
                      1'b1);
            end
        end
        tick();
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
